// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the parametrised UART core.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic int frame_cycles(input int clk_div, input int data_bits,
                                      input int parity, input int stop_bits);
    return clk_div * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO; an extra pointer MSB separates full from empty.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_acc;
  logic             w_pop_acc;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_acc  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_acc = i_push && (!o_full || w_pop_acc);
  assign o_data     = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_param_core.sv
// UART transmitter/receiver with configurable framing and a FIFO per direction.
module uart_param_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 108,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 tx_busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = 3;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP = IW'(STOP_BITS - 1);

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    if (PARITY == PAR_ODD) return ~(^d);
    return ^d;
  endfunction

  // ---------------- TX ----------------
  logic                 w_txf_push;
  logic                 w_txf_full;
  logic                 w_txf_empty;
  logic [DATA_BITS-1:0] w_txf_dout;
  logic                 w_tx_pop;
  logic                 w_tx_tick;
  logic                 w_tx_bit;
  tx_state_t            r_tx_state;
  tx_state_t            w_tx_next;
  logic [CW-1:0]        r_tx_cnt;
  logic [IW-1:0]        r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_data;
  logic                 r_txd;

  assign tx_ready   = !w_txf_full;
  assign w_txf_push = tx_valid && tx_ready;
  assign w_tx_tick  = (r_tx_cnt == CNT_LAST);
  assign tx_busy    = (r_tx_state != TX_IDLE) || !w_txf_empty;
  assign txd        = r_txd;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_txf_push),
    .i_data  (tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_txf_dout),
    .o_full  (w_txf_full),
    .o_empty (w_txf_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tx_state <= TX_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_txf_empty) begin
          w_tx_pop  = 1'b1;
          w_tx_next = TX_START;
        end
      end
      TX_START:  if (w_tx_tick) w_tx_next = TX_DATA;
      TX_DATA: begin
        if (w_tx_tick && (r_tx_idx == IDX_DATA))
          w_tx_next = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
      end
      TX_PARITY: if (w_tx_tick) w_tx_next = TX_STOP;
      TX_STOP: begin
        // Back-to-back frames: pop the next word on the last stop cycle, no idle gap.
        if (w_tx_tick && (r_tx_idx == IDX_STOP)) begin
          if (!w_txf_empty) begin
            w_tx_pop  = 1'b1;
            w_tx_next = TX_START;
          end else begin
            w_tx_next = TX_IDLE;
          end
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_bit = 1'b1;
    case (r_tx_state)
      TX_START:  w_tx_bit = 1'b0;
      TX_DATA:   w_tx_bit = r_tx_data[r_tx_idx];
      TX_PARITY: w_tx_bit = parity_bit(r_tx_data);
      default:   w_tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_cnt <= '0;
      r_tx_idx <= '0;
      r_txd    <= 1'b1;
    end else begin
      r_txd <= w_tx_bit;
      if ((r_tx_state == TX_IDLE) || w_tx_tick) r_tx_cnt <= '0;
      else                                      r_tx_cnt <= r_tx_cnt + CNT_ONE;
      if (w_tx_next != r_tx_state) r_tx_idx <= '0;
      else if (w_tx_tick)          r_tx_idx <= r_tx_idx + IDX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_pop) r_tx_data <= w_txf_dout;
  end

  // ---------------- RX ----------------
  logic                 r_rx_s1;
  logic                 r_rx_s2;
  logic                 w_rx;
  rx_state_t            r_rx_state;
  rx_state_t            w_rx_next;
  logic [CW-1:0]        r_rx_cnt;
  logic [IW-1:0]        r_rx_idx;
  logic                 r_rx_ferr;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 w_rx_strobe;
  logic                 w_rx_final;
  logic                 w_rx_bad_stop;
  logic                 w_rx_push;
  logic                 w_rx_push_acc;
  logic                 w_rx_par_bad;
  logic                 w_rxf_full;
  logic                 w_rxf_empty;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic                 r_overrun;

  assign w_rx          = r_rx_s2;
  // START waits half a bit to land mid-bit; every later sample is a full bit apart.
  assign w_rx_strobe   = (r_rx_state == RX_START) ? (r_rx_cnt == CNT_HALF)
                                                  : (r_rx_cnt == CNT_LAST);
  assign rx_valid      = !w_rxf_empty;
  assign rx_parity_err = r_par_err;
  assign rx_frame_err  = r_frame_err;
  assign rx_overrun    = r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:   if (!w_rx) w_rx_next = RX_START;
      RX_START:  if (w_rx_strobe) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (w_rx_strobe && (r_rx_idx == IDX_DATA))
          w_rx_next = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
      end
      RX_PARITY: if (w_rx_strobe) w_rx_next = RX_STOP;
      RX_STOP:   if (w_rx_strobe && (r_rx_idx == IDX_STOP)) w_rx_next = RX_IDLE;
      default:   w_rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_final    = (r_rx_state == RX_STOP) && w_rx_strobe && (r_rx_idx == IDX_STOP);
    w_rx_bad_stop = w_rx_final && (!w_rx || r_rx_ferr);
    w_rx_push     = w_rx_final && !w_rx_bad_stop;
    w_rx_push_acc = w_rx_push && (!w_rxf_full || rx_ready);
    w_rx_par_bad  = (PARITY != PAR_NONE) && (r_rx_par != parity_bit(r_rx_shift));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_cnt    <= '0;
      r_rx_idx    <= '0;
      r_rx_ferr   <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if ((r_rx_state == RX_IDLE) || w_rx_strobe) r_rx_cnt <= '0;
      else                                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
      if (w_rx_next != r_rx_state) r_rx_idx <= '0;
      else if (w_rx_strobe)        r_rx_idx <= r_rx_idx + IDX_ONE;
      // Remembers a low first stop bit so the word is dropped at the final stop sample.
      if (r_rx_state == RX_IDLE)                                  r_rx_ferr <= 1'b0;
      else if ((r_rx_state == RX_STOP) && w_rx_strobe && !w_rx)   r_rx_ferr <= 1'b1;
      r_par_err   <= w_rx_push_acc && w_rx_par_bad;
      r_frame_err <= w_rx_bad_stop;
      r_overrun   <= w_rx_push && w_rxf_full && !rx_ready;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_rx_state == RX_DATA) && w_rx_strobe)   r_rx_shift[r_rx_idx] <= w_rx;
    if ((r_rx_state == RX_PARITY) && w_rx_strobe) r_rx_par <= w_rx;
  end

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (rx_ready),
    .o_data  (rx_data),
    .o_full  (w_rxf_full),
    .o_empty (w_rxf_empty)
  );

endmodule

// File: tb/tb_uart_param_core.sv
// Scoreboard bench: 8N1 depth-4 core, 7E2 loopback core and 8O1 core side by side.
module tb_uart_param_core;
  import uart_pkg::*;

  localparam int DIV = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // core A: 8N1, depth 4, bench-driven rxd
  logic       rxd_a, txd_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
  logic       perr_a, ferr_a, ovr_a, busy_a;
  logic [7:0] tx_data_a, rx_data_a;
  // core B: 7E2, txd looped to rxd
  logic       txd_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
  logic       perr_b, ferr_b, ovr_b, busy_b;
  logic [6:0] tx_data_b, rx_data_b;
  // core C: 8O1, bench-driven rxd
  logic       rxd_c, txd_c, tx_valid_c, tx_ready_c, rx_valid_c, rx_ready_c;
  logic       perr_c, ferr_c, ovr_c, busy_c;
  logic [7:0] tx_data_c, rx_data_c;

  uart_param_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1),
                    .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .txd(txd_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_parity_err(perr_a),
    .rx_frame_err(ferr_a), .rx_overrun(ovr_a), .tx_busy(busy_a));

  uart_param_core #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2),
                    .FIFO_DEPTH(8)) u_b (
    .clk(clk), .rst(rst), .rxd(txd_b), .txd(txd_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_parity_err(perr_b),
    .rx_frame_err(ferr_b), .rx_overrun(ovr_b), .tx_busy(busy_b));

  uart_param_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1),
                    .FIFO_DEPTH(8)) u_c (
    .clk(clk), .rst(rst), .rxd(rxd_c), .txd(txd_c), .tx_data(tx_data_c),
    .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .rx_data(rx_data_c),
    .rx_valid(rx_valid_c), .rx_ready(rx_ready_c), .rx_parity_err(perr_c),
    .rx_frame_err(ferr_c), .rx_overrun(ovr_c), .tx_busy(busy_c));

  logic [7:0] q_a[$], q_b[$], q_c[$];
  int n_perr_a = 0, n_ferr_a = 0, n_ovr_a = 0, n_pop_a = 0;
  int n_err_b = 0, n_pop_b = 0, n_busy_b = 0;
  int n_perr_c = 0, n_ferr_c = 0, n_pop_c = 0, n_perr_vld_c = 0;

  always @(negedge clk) begin
    if (!rst) begin
      n_perr_a += int'(perr_a);
      n_ferr_a += int'(ferr_a);
      n_ovr_a  += int'(ovr_a);
      if (rx_valid_a && rx_ready_a) begin
        chk("a_q_nonempty", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) chk("a_rx_data", 32'(rx_data_a), 32'(q_a.pop_front()));
        n_pop_a++;
      end
      n_err_b  += int'(perr_b) + int'(ferr_b) + int'(ovr_b);
      n_busy_b += int'(busy_b);
      if (rx_valid_b && rx_ready_b) begin
        chk("b_q_nonempty", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) chk("b_rx_data", 32'(rx_data_b), 32'(q_b.pop_front()));
        n_pop_b++;
      end
      n_perr_c     += int'(perr_c);
      n_ferr_c     += int'(ferr_c) + int'(ovr_c);
      n_perr_vld_c += int'(perr_c && rx_valid_c);
      if (rx_valid_c && rx_ready_c) begin
        chk("c_q_nonempty", 32'(q_c.size() != 0), 32'd1);
        if (q_c.size() != 0) chk("c_rx_data", 32'(rx_data_c), 32'(q_c.pop_front()));
        n_pop_c++;
      end
    end
  end

  task automatic drive_rx(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rxd_a = bits[i];
      else          rxd_c = bits[i];
      repeat (DIV) @(negedge clk);
    end
    if (sel == 0) rxd_a = 1'b1;
    else          rxd_c = 1'b1;
  endtask

  task automatic tx_frame_a(input logic [7:0] d, input string tag);
    logic [9:0] seq;
    logic       exp;
    seq = {1'b1, d, 1'b0};
    @(negedge clk);
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    chk({tag, "_tx_ready"}, 32'(tx_ready_a), 32'd1);
    @(posedge clk);
    #1 tx_valid_a = 1'b0;
    for (int c = 0; c < 166; c++) begin
      @(negedge clk);
      if (c < 2)                   exp = 1'b1;
      else if ((c - 2) / DIV < 10) exp = seq[(c - 2) / DIV];
      else                         exp = 1'b1;
      if (c < 3 || (c - 2) % DIV == 0 || (c - 2) % DIV == DIV - 1 || c >= 162)
        chk($sformatf("%s_txd_c%0d", tag, c), 32'(txd_a), 32'(exp));
      if (c == 0 || c == 160) chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy_a), 32'd1);
      if (c == 163)           chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy_a), 32'd0);
    end
  endtask

  logic [6:0] b_words [3] = '{7'h00, 7'h7F, 7'h55};
  logic [7:0] a_words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    rxd_a = 1'b1; rxd_c = 1'b1;
    tx_valid_a = 1'b0; tx_valid_b = 1'b0; tx_valid_c = 1'b0;
    tx_data_a = '0; tx_data_b = '0; tx_data_c = '0;
    rx_ready_a = 1'b0; rx_ready_b = 1'b1; rx_ready_c = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd",      32'(txd_a),      32'd1);
    chk("rst_tx_ready", 32'(tx_ready_a), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid_a), 32'd0);
    chk("rst_rx_data",  32'(rx_data_a),  32'd0);
    chk("rst_errs",     32'({perr_a, ferr_a, ovr_a}), 32'd0);
    chk("rst_busy",     32'(busy_a),     32'd0);
    chk("rst_txd_b",    32'(txd_b),      32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    tx_frame_a(8'hA5, "a5");

    // 7E2 loopback, three words back to back
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tx_data_b  = b_words[i];
      tx_valid_b = 1'b1;
      chk("b_tx_ready", 32'(tx_ready_b), 32'd1);
      q_b.push_back({1'b0, b_words[i]});
      @(posedge clk);
      #1;
    end
    tx_valid_b = 1'b0;
    for (int w = 0; w < 2000 && busy_b; w++) @(negedge clk);
    chk("b_busy_done", 32'(busy_b), 32'd0);
    repeat (5) @(negedge clk);
    chk("b_no_gap_busy", 32'(n_busy_b), 32'(3 * frame_cycles(DIV, 7, PAR_EVEN, 2) + 1));
    chk("b_pops", 32'(n_pop_b), 32'd3);
    chk("b_q_drained", 32'(q_b.size()), 32'd0);
    chk("b_errors", 32'(n_err_b), 32'd0);

    // 8O1: 0x03 has two ones, so the odd-parity bit is 1
    q_c.push_back(8'h03);
    drive_rx(1, {5'h1f, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    repeat (4) @(negedge clk);
    chk("c_good_par_no_err", 32'(n_perr_c), 32'd0);
    q_c.push_back(8'h03);
    drive_rx(1, {5'h1f, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
    repeat (4) @(negedge clk);
    chk("c_bad_par_err", 32'(n_perr_c), 32'd1);
    chk("c_perr_with_push", 32'(n_perr_vld_c), 32'd1);
    chk("c_pops", 32'(n_pop_c), 32'd2);
    chk("c_q_drained", 32'(q_c.size()), 32'd0);
    chk("c_no_frame_err", 32'(n_ferr_c), 32'd0);

    // A: low stop bit, then a quarter-bit glitch
    drive_rx(0, {6'h3f, 1'b0, 8'h5A, 1'b0}, 10);
    repeat (30) @(negedge clk);
    chk("a_frame_err", 32'(n_ferr_a), 32'd1);
    chk("a_ferr_no_valid", 32'(rx_valid_a), 32'd0);
    rxd_a = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rxd_a = 1'b1;
    repeat (40) @(negedge clk);
    chk("a_glitch_no_valid", 32'(rx_valid_a), 32'd0);
    chk("a_glitch_no_ferr", 32'(n_ferr_a), 32'd1);
    chk("a_no_perr", 32'(n_perr_a), 32'd0);

    // A: five frames into a depth-4 FIFO with the consumer stalled
    for (int i = 0; i < 5; i++) begin
      if (i < 4) q_a.push_back(a_words[i]);
      drive_rx(0, {6'h3f, 1'b1, a_words[i], 1'b0}, 10);
    end
    repeat (4) @(negedge clk);
    chk("a_overrun", 32'(n_ovr_a), 32'd1);
    chk("a_ovr_no_ferr", 32'(n_ferr_a), 32'd1);
    chk("a_full_valid", 32'(rx_valid_a), 32'd1);
    chk("a_head", 32'(rx_data_a), 32'h11);
    @(posedge clk);
    #1 rx_ready_a = 1'b1;
    repeat (10) @(negedge clk);
    chk("a_pops", 32'(n_pop_a), 32'd4);
    chk("a_q_drained", 32'(q_a.size()), 32'd0);
    chk("a_drained_valid", 32'(rx_valid_a), 32'd0);

    // reset in the middle of data bit 3 of 0xC3 (a zero bit)
    @(negedge clk);
    tx_data_a  = 8'hC3;
    tx_valid_a = 1'b1;
    @(posedge clk);
    #1 tx_valid_a = 1'b0;
    repeat (74) @(negedge clk);
    chk("rst_pre_txd", 32'(txd_a), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_txd",      32'(txd_a),      32'd1);
    chk("rst_mid_tx_ready", 32'(tx_ready_a), 32'd1);
    chk("rst_mid_busy",     32'(busy_a),     32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tx_frame_a(8'h96, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
